// File: rtl/yolo_top_deadlock_watchdog.sv
// Top-level deadlock watchdog: aggregates per-stage block flags, declares a sticky
// deadlock after THRESHOLD consecutive non-idle blocked cycles, and counts events.
module yolo_top_deadlock_watchdog #(
    parameter int unsigned NUM_MON   = 4,
    parameter int unsigned THRESHOLD = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [NUM_MON-1:0] block_sigs,
    input  logic               ap_idle,
    input  logic               clr,
    output logic               deadlock,
    output logic [NUM_MON-1:0] deadlock_src,
    output logic               irq,
    output logic [CNT_W-1:0]   blocked_cycles,
    output logic [7:0]         event_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(THRESHOLD);

    logic [1:0]         state_q,    state_d;
    logic [CNT_W-1:0]   blocked_q,  blocked_d;
    logic               deadlock_q, deadlock_d;
    logic               irq_q,      irq_d;
    logic [NUM_MON-1:0] src_q,      src_d;
    logic [7:0]         event_q,    event_d;

    logic stalled_c;
    assign stalled_c = (|block_sigs) && !ap_idle;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            blocked_q  <= '0;
            deadlock_q <= 1'b0;
            irq_q      <= 1'b0;
            src_q      <= '0;
            event_q    <= '0;
        end else begin
            state_q    <= state_d;
            blocked_q  <= blocked_d;
            deadlock_q <= deadlock_d;
            irq_q      <= irq_d;
            src_q      <= src_d;
            event_q    <= event_d;
        end
    end

    // clr outranks everything, including a declaration on the same edge
    always_comb begin
        state_d    = state_q;
        blocked_d  = blocked_q;
        deadlock_d = deadlock_q;
        irq_d      = 1'b0;
        src_d      = src_q;
        event_d    = event_q;

        if (clr) begin
            state_d    = ST_IDLE;
            blocked_d  = '0;
            deadlock_d = 1'b0;
            src_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stalled_c) begin
                        state_d   = ST_COUNT;
                        blocked_d = CNT_W'(1);
                    end else begin
                        blocked_d = '0;
                    end
                end
                ST_COUNT: begin
                    if (!stalled_c) begin
                        state_d   = ST_IDLE;
                        blocked_d = '0;
                    end else if (blocked_q == CNT_LAST) begin
                        state_d    = ST_DEAD;
                        blocked_d  = CNT_FULL;
                        deadlock_d = 1'b1;
                        irq_d      = 1'b1;
                        src_d      = block_sigs;
                        if (event_q != 8'hFF) begin
                            event_d = event_q + 8'd1;
                        end
                    end else begin
                        blocked_d = blocked_q + CNT_W'(1);
                    end
                end
                ST_DEAD: begin
                    state_d = ST_DEAD;
                end
                default: begin
                    state_d   = ST_IDLE;
                    blocked_d = '0;
                end
            endcase
        end
    end

    assign deadlock       = deadlock_q;
    assign deadlock_src   = src_q;
    assign irq            = irq_q;
    assign blocked_cycles = blocked_q;
    assign event_cnt      = event_q;

endmodule

// File: tb/tb_yolo_top_deadlock_watchdog.sv
// Bench for the deadlock watchdog: directed scenarios plus random traffic, all
// checked every cycle against a run-length reference model.
module tb_yolo_top_deadlock_watchdog;

    localparam int unsigned NUM_MON   = 4;
    localparam int unsigned THRESHOLD = 8;
    localparam int unsigned CNT_W     = 16;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic [NUM_MON-1:0] block_sigs = '0;
    logic               ap_idle = 1'b0;
    logic               clr = 1'b0;
    logic               deadlock;
    logic [NUM_MON-1:0] deadlock_src;
    logic               irq;
    logic [CNT_W-1:0]   blocked_cycles;
    logic [7:0]         event_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: length of the current qualifying run plus the latched result
    int          m_run;
    bit          m_latched;
    logic [3:0]  m_src;
    bit          m_irq;
    int          m_ev;

    yolo_top_deadlock_watchdog #(
        .NUM_MON  (NUM_MON),
        .THRESHOLD(THRESHOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .block_sigs    (block_sigs),
        .ap_idle       (ap_idle),
        .clr           (clr),
        .deadlock      (deadlock),
        .deadlock_src  (deadlock_src),
        .irq           (irq),
        .blocked_cycles(blocked_cycles),
        .event_cnt     (event_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_latched = 0; m_src = '0; m_irq = 0; m_ev = 0;
    endtask

    task automatic model_edge(input logic [3:0] b, input logic idle, input logic c);
        m_irq = 0;
        if (c) begin
            m_latched = 0; m_run = 0; m_src = '0;
        end else if (!m_latched) begin
            if ((b != 0) && !idle) begin
                m_run++;
                if (m_run == THRESHOLD) begin
                    m_latched = 1; m_irq = 1; m_src = b;
                    if (m_ev < 255) m_ev++;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".deadlock"}, 32'(deadlock), 32'(m_latched));
        chk({tag, ".irq"},      32'(irq),      32'(m_irq));
        chk({tag, ".src"},      32'(deadlock_src), 32'(m_src));
        chk({tag, ".blocked"},  32'(blocked_cycles), 32'(m_run));
        chk({tag, ".events"},   32'(event_cnt), 32'(m_ev));
    endtask

    // drive one cycle of inputs, apply it to the model at the edge, compare at negedge
    task automatic tick(input string tag, input logic [3:0] b, input logic idle, input logic c);
        block_sigs = b; ap_idle = idle; clr = c;
        @(posedge ap_clk);
        model_edge(b, idle, c);
        @(negedge ap_clk);
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 ap_rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        block_sigs = '0; ap_idle = 0; clr = 0;
        #1;
        check_all("por");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // single-source stall declared on the 8th edge, irq gone on the 9th
        for (int i = 0; i < 8; i++) tick("r29", 4'b0010, 0, 0);
        chk("r29.dl_edge8", 32'(deadlock), 32'd1);
        chk("r29.src_edge8", 32'(deadlock_src), 32'h2);
        tick("r29b", 4'b0010, 0, 0);
        chk("r29.irq_edge9", 32'(irq), 32'd0);
        tick("r29c", 4'b0000, 0, 1);

        // one gap cycle restarts the run
        for (int i = 0; i < 7; i++) tick("r30a", 4'b1111, 0, 0);
        tick("r30gap", 4'b0000, 0, 0);
        for (int i = 0; i < 7; i++) tick("r30b", 4'b1111, 0, 0);
        chk("r30.no_dl_edge15", 32'(deadlock), 32'd0);
        tick("r30c", 4'b1111, 0, 0);
        chk("r30.dl_edge16", 32'(deadlock), 32'd1);
        tick("r30clr", 4'b0000, 0, 1);

        // idle kernel masks the block
        for (int i = 0; i < 20; i++) tick("r31", 4'b1000, 1, 0);
        chk("r31.blocked", 32'(blocked_cycles), 32'd0);

        // latched flag survives unblocking until clr
        for (int i = 0; i < 8; i++) tick("r32a", 4'b0100, 0, 0);
        for (int i = 0; i < 5; i++) tick("r32b", 4'b0000, 0, 0);
        chk("r32.held", 32'(deadlock), 32'd1);
        tick("r32clr", 4'b0000, 0, 1);
        chk("r32.ev", 32'(event_cnt), 32'(m_ev));

        // clr beats a declaration on the same edge
        for (int i = 0; i < 7; i++) tick("r33a", 4'b0001, 0, 0);
        tick("r33clr", 4'b0001, 0, 1);
        chk("r33.irq", 32'(irq), 32'd0);
        tick("r33b", 4'b0000, 0, 0);

        // asynchronous reset mid-run discards progress
        for (int i = 0; i < 5; i++) tick("r34a", 4'b0011, 0, 0);
        block_sigs = 4'b0011;
        pulse_reset("r34rst");
        for (int i = 0; i < 7; i++) tick("r34b", 4'b0011, 0, 0);
        chk("r34.no_dl_edge7", 32'(deadlock), 32'd0);
        tick("r34c", 4'b0011, 0, 0);
        chk("r34.dl_edge8", 32'(deadlock), 32'd1);
        tick("r34clr", 4'b0000, 0, 1);

        // reset while latched, then drive event_cnt to saturation
        for (int i = 0; i < 8; i++) tick("dlrst", 4'b1010, 0, 0);
        pulse_reset("dlrst_rst");
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < 8; i++) tick("sat", 4'(k % 15 + 1), 0, 0);
            tick("satclr", 4'b0000, 0, 1);
        end
        chk("sat.events", 32'(event_cnt), 32'd255);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] b;
            logic       idl, c;
            b   = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(1, 15)) : 4'b0000;
            idl = ($urandom_range(0, 99) < 5);
            c   = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 999) < 4) pulse_reset("rnd_rst");
            else tick("rnd", b, idl, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/yolo_top_deadlock_watchdog.md
YOLO_TOP_DEADLOCK_WATCHDOG -- requirements
Module: yolo_top_deadlock_watchdog

Interface
REQ-001 SHALL have parameter NUM_MON, default 4, meaning the number of per-stage deadlock monitor block inputs (1..16).
REQ-002 SHALL have parameter THRESHOLD, default 1024, meaning the consecutive blocked cycles that declare a deadlock (2..65535).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the blocked-cycle counter; it holds THRESHOLD.
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port block_sigs, input, NUM_MON bits: registered "block" outputs of the upstream per-module deadlock monitors.
REQ-007 SHALL have port ap_idle, input, 1 bit: the top kernel is idle, so a block is not a deadlock.
REQ-008 SHALL have port clr, input, 1 bit: synchronous single-cycle clear of a latched deadlock.
REQ-009 SHALL have port deadlock, output, 1 bit: sticky deadlock flag.
REQ-010 SHALL have port deadlock_src, output, NUM_MON bits: snapshot of block_sigs at declaration.
REQ-011 SHALL have port irq, output, 1 bit: one-cycle pulse on declaration.
REQ-012 SHALL have port blocked_cycles, output, CNT_W bits: current consecutive blocked-cycle count.
REQ-013 SHALL have port event_cnt, output, 8 bits: saturating count of declared deadlocks.

Function
REQ-014 SHALL define any_block as the OR of block_sigs, sampled on each rising edge.
REQ-015 SHALL implement three states: IDLE, COUNT, DEADLOCK; all outputs registered.
REQ-016 In IDLE with any_block=1 and ap_idle=0: SHALL go to COUNT and set blocked_cycles=1; otherwise stay with blocked_cycles=0.
REQ-017 In COUNT with any_block=0 or ap_idle=1: SHALL go to IDLE and set blocked_cycles=0 on the same edge.
REQ-018 In COUNT with any_block=1, ap_idle=0 and blocked_cycles<THRESHOLD-1: SHALL increment blocked_cycles by 1.
REQ-019 In COUNT with any_block=1, ap_idle=0 and blocked_cycles==THRESHOLD-1: SHALL do all of the following on that edge: go to DEADLOCK, set blocked_cycles=THRESHOLD, deadlock=1, irq=1, deadlock_src=block_sigs, and event_cnt+1 saturating at 255.
REQ-020 Latency: deadlock SHALL rise on the THRESHOLD-th consecutive edge at which any_block=1 and ap_idle=0.
REQ-021 irq SHALL be high for exactly one cycle per declaration and 0 at all other times.
REQ-022 In DEADLOCK: SHALL hold deadlock, deadlock_src and blocked_cycles regardless of block_sigs or ap_idle until clr.
REQ-023 clr=1 in any state SHALL force IDLE and clear blocked_cycles, deadlock and deadlock_src; event_cnt SHALL be unaffected.
REQ-024 clr SHALL take priority over a simultaneous declaration on the same edge: no irq, no event_cnt increment, state IDLE.
REQ-025 A single any_block=0 cycle inside COUNT SHALL restart counting from zero (no hysteresis).
REQ-026 blocked_cycles SHALL never exceed THRESHOLD and SHALL never wrap.

Reset
REQ-027 ap_rst_n=0 SHALL immediately, without a clock edge, force IDLE, deadlock=0, irq=0, deadlock_src=0, blocked_cycles=0 and event_cnt=0.
REQ-028 Reset asserted mid-COUNT or in DEADLOCK SHALL discard all progress; counting SHALL resume only from edges after ap_rst_n returns to 1.

Verification (NUM_MON=4, THRESHOLD=8)
REQ-029 block_sigs=4'b0010, ap_idle=0 held for 8 edges -> deadlock=1 and irq=1 on edge 8, deadlock_src=4'b0010, event_cnt=1, blocked_cycles=8; irq=0 on edge 9.
REQ-030 block_sigs high for 7 edges, 0 for 1 edge, then high for 8 edges -> no deadlock before edge 16; declared on edge 16.
REQ-031 block_sigs=4'b1000 with ap_idle=1 for 20 edges -> deadlock stays 0 and blocked_cycles stays 0.
REQ-032 Deadlock latched, then block_sigs=0 for 5 edges, then clr pulse -> deadlock holds 1 until the clr edge, then 0 with deadlock_src=0 and event_cnt=1.
REQ-033 clr asserted on the 8th blocked edge -> deadlock=0, irq=0, event_cnt unchanged, state IDLE.
REQ-034 ap_rst_n pulsed low asynchronously after 5 blocked edges -> outputs zero immediately; with continued block, deadlock rises 8 edges after reset release.
